// File: rtl/axi_burst_addr_latch.sv
// Single-entry AXI3 address latch: holds one burst and replays it as peripheral-width accesses.
// Optional 4KB page-crossing flag on INCR bursts: define AXI_ADDR_LATCH_4K_CHECK_EN to add O_ERR.
//
// state   | meaning
// S_IDLE  | no burst held, READY offered upstream
// S_BURST | burst held, presenting accesses on O_* until the last one is consumed
module axi_burst_addr_latch #(
    parameter int masters = 4,
    parameter int width   = 22,
    parameter int p_size  = 3,
    parameter int id_bits = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [masters-1:0] MASTER,
    input  logic [id_bits-1:0] ID,
    input  logic [width-1:0]   ADDR,
    input  logic [3:0]         LEN,
    input  logic [2:0]         SIZE,
    input  logic [1:0]         BURST,
    input  logic [1:0]         LOCK,
    input  logic [3:0]         CACHE,
    input  logic [2:0]         PROT,
    input  logic               VALID,
    output logic               READY,
    output logic [masters-1:0] O_MASTER,
    output logic [id_bits-1:0] O_ID,
    output logic [width-1:0]   O_ADDR,
    output logic               O_LAST,
    output logic               O_VALID,
    input  logic               O_READY
`ifdef AXI_ADDR_LATCH_4K_CHECK_EN
    ,
    output logic               O_ERR
`endif
);

    localparam logic [2:0] P_SIZE = 3'(p_size);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t state, state_next;

    logic [masters-1:0] master_q;
    logic [id_bits-1:0] id_q;
    logic [width-1:0]   base_q, addr_q, wrap_mask_q;
    logic [1:0]         burst_q;
    logic [2:0]         step_lg_q;
    logic [11:0]        rem_q;
    logic [7:0]         sub_rem_q, sub_reload_q;

    logic               accept, handshake, last;
    logic               size_gt;
    logic [2:0]         in_step_lg, in_subs_lg;
    logic [7:0]         in_subs_m1;
    logic [11:0]        in_n_m1;
    logic [width-1:0]   in_wrap_mask;
    logic [width-1:0]   step_mask, incr_addr, addr_adv;
    logic               unused_ok;

    assign unused_ok = ^{LOCK, CACHE, PROT};

    assign accept    = VALID && READY;
    assign handshake = O_VALID && O_READY;
    assign last      = (state == S_BURST) && (rem_q == 12'd0);

    assign READY    = (state == S_IDLE) && !RESET;
    assign O_VALID  = (state == S_BURST);
    assign O_LAST   = last;
    assign O_ADDR   = addr_q;
    assign O_MASTER = master_q;
    assign O_ID     = id_q;

    // Beats wider than the peripheral split into 2^(SIZE-p_size) sub-accesses.
    assign size_gt      = SIZE > P_SIZE;
    assign in_step_lg   = size_gt ? P_SIZE : SIZE;
    assign in_subs_lg   = size_gt ? (SIZE - P_SIZE) : 3'd0;
    assign in_subs_m1   = (8'd1 << in_subs_lg) - 8'd1;
    assign in_n_m1      = ((12'(LEN) + 12'd1) << in_subs_lg) - 12'd1;
    assign in_wrap_mask = ((width'(LEN) + width'(1)) << SIZE) - width'(1);

    assign step_mask = (width'(1) << step_lg_q) - width'(1);
    assign incr_addr = (addr_q & ~step_mask) + step_mask + width'(1);

    always_comb begin
        addr_adv = incr_addr;
        case (burst_q)
            2'b00:   addr_adv = (sub_rem_q == 8'd0) ? base_q : incr_addr;
            2'b10:   addr_adv = (base_q & ~wrap_mask_q) | (incr_addr & wrap_mask_q);
            default: addr_adv = incr_addr;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept)            state_next = S_BURST;
            S_BURST: if (handshake && last) state_next = S_IDLE;
            default:                        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            master_q     <= '0;
            id_q         <= '0;
            base_q       <= '0;
            addr_q       <= '0;
            wrap_mask_q  <= '0;
            burst_q      <= '0;
            step_lg_q    <= '0;
            rem_q        <= '0;
            sub_rem_q    <= '0;
            sub_reload_q <= '0;
        end else if (accept) begin
            master_q     <= MASTER;
            id_q         <= ID;
            base_q       <= ADDR;
            addr_q       <= ADDR;
            wrap_mask_q  <= in_wrap_mask;
            burst_q      <= BURST;
            step_lg_q    <= in_step_lg;
            rem_q        <= in_n_m1;
            sub_rem_q    <= in_subs_m1;
            sub_reload_q <= in_subs_m1;
        end else if (handshake && !last) begin
            addr_q    <= addr_adv;
            rem_q     <= rem_q - 12'd1;
            sub_rem_q <= (sub_rem_q == 8'd0) ? sub_reload_q : sub_rem_q - 8'd1;
        end
    end

`ifdef AXI_ADDR_LATCH_4K_CHECK_EN
    logic err_q;
    logic incr_burst;

    assign incr_burst = (burst_q == 2'b01) || (burst_q == 2'b11);
    assign O_ERR      = err_q;

    // Sticky for the rest of the burst once any access leaves the start page.
    always_ff @(posedge CLK) begin
        if (RESET)
            err_q <= 1'b0;
        else if (accept)
            err_q <= 1'b0;
        else if (handshake && !last && incr_burst &&
                 (addr_adv[width-1:12] != base_q[width-1:12]))
            err_q <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_axi_burst_addr_latch.sv
// Scoreboard bench for axi_burst_addr_latch: requests push expected accesses, a monitor pops on handshake.
module tb_axi_burst_addr_latch;

    localparam int MASTERS = 4;
    localparam int WIDTH   = 22;
    localparam int PSIZE   = 3;
    localparam int IDB     = 2;

    logic               CLK = 1'b0;
    logic               RESET = 1'b1;
    logic [MASTERS-1:0] MASTER = '0;
    logic [IDB-1:0]     ID = '0;
    logic [WIDTH-1:0]   ADDR = '0;
    logic [3:0]         LEN = '0;
    logic [2:0]         SIZE = '0;
    logic [1:0]         BURST = '0;
    logic [1:0]         LOCK = '0;
    logic [3:0]         CACHE = '0;
    logic [2:0]         PROT = '0;
    logic               VALID = 1'b0;
    logic               READY;
    logic [MASTERS-1:0] O_MASTER;
    logic [IDB-1:0]     O_ID;
    logic [WIDTH-1:0]   O_ADDR;
    logic               O_LAST;
    logic               O_VALID;
    logic               O_READY = 1'b1;
`ifdef AXI_ADDR_LATCH_4K_CHECK_EN
    logic               O_ERR;
`endif

    axi_burst_addr_latch #(
        .masters(MASTERS), .width(WIDTH), .p_size(PSIZE), .id_bits(IDB)
    ) dut (
        .CLK(CLK), .RESET(RESET), .MASTER(MASTER), .ID(ID), .ADDR(ADDR),
        .LEN(LEN), .SIZE(SIZE), .BURST(BURST), .LOCK(LOCK), .CACHE(CACHE),
        .PROT(PROT), .VALID(VALID), .READY(READY), .O_MASTER(O_MASTER),
        .O_ID(O_ID), .O_ADDR(O_ADDR), .O_LAST(O_LAST), .O_VALID(O_VALID),
        .O_READY(O_READY)
`ifdef AXI_ADDR_LATCH_4K_CHECK_EN
        , .O_ERR(O_ERR)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [WIDTH-1:0]   addr;
        logic               last;
        logic [IDB-1:0]     id;
        logic [MASTERS-1:0] master;
    } exp_t;

    exp_t               exp_q[$];
    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic [MASTERS-1:0] cur_master = '0;
    logic [IDB-1:0]     cur_id = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic void expect_acc(input logic [WIDTH-1:0] a, input logic l);
        exp_t e;
        e.addr   = a;
        e.last   = l;
        e.id     = cur_id;
        e.master = cur_master;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic present(input logic [MASTERS-1:0] m, input logic [IDB-1:0] id,
                           input logic [WIDTH-1:0] a, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        MASTER = m; ID = id; ADDR = a; LEN = len; SIZE = size; BURST = burst;
        LOCK = 2'b11; CACHE = 4'hF; PROT = 3'h7;
        VALID = 1'b1;
        cur_master = m;
        cur_id = id;
    endtask

    task automatic wait_accept(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 60; i++) begin
            if (READY) begin
                tick();
                VALID = 1'b0;
                done = 1;
                break;
            end
            tick();
        end
        if (!done) begin
            VALID = 1'b0;
            fail_now(name);
        end
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !O_VALID) begin
                done = 1;
                break;
            end
            tick();
        end
        if (!done) begin
            fail_now(name);
            exp_q.delete();
        end
    endtask

    // Monitor: compares every consumed access against the scoreboard head.
    always @(negedge CLK) begin
        exp_t e;
        if (!RESET && O_VALID) begin
            check("ready_low_while_busy", 32'(READY), 32'd0);
            if (O_READY) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_access", O_ADDR, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("o_addr", 32'(O_ADDR), 32'(e.addr));
                    check("o_last", 32'(O_LAST), 32'(e.last));
                    check("o_id", 32'(O_ID), 32'(e.id));
                    check("o_master", 32'(O_MASTER), 32'(e.master));
                end
            end
        end
    end

    initial begin
        bit got;

        // Reset held two cycles
        RESET = 1'b1;
        tick();
        tick();
        check("rst_ready", 32'(READY), 32'd0);
        check("rst_o_valid", 32'(O_VALID), 32'd0);
        check("rst_o_last", 32'(O_LAST), 32'd0);
        check("rst_o_addr", 32'(O_ADDR), 32'd0);
        RESET = 1'b0;
        tick();
        check("ready_after_rst", 32'(READY), 32'd1);

        // INCR aligned
        present(4'b0001, 2'd0, 22'h100, 4'd3, 3'd3, 2'b01);
        expect_acc(22'h100, 0); expect_acc(22'h108, 0);
        expect_acc(22'h110, 0); expect_acc(22'h118, 1);
        wait_accept("acc_incr");
        wait_drain("drain_incr");

        // WRAP 4 x 8 bytes starting mid-container
        present(4'b0010, 2'd1, 22'h118, 4'd3, 3'd3, 2'b10);
        expect_acc(22'h118, 0); expect_acc(22'h100, 0);
        expect_acc(22'h108, 0); expect_acc(22'h110, 1);
        wait_accept("acc_wrap");
        wait_drain("drain_wrap");

        // FIXED
        present(4'b0100, 2'd3, 22'h40, 4'd2, 3'd3, 2'b00);
        expect_acc(22'h40, 0); expect_acc(22'h40, 0); expect_acc(22'h40, 1);
        wait_accept("acc_fixed");
        wait_drain("drain_fixed");

        // Stall with a second request waiting, then wide single beat split in two
        O_READY = 1'b0;
        present(4'b1000, 2'd1, 22'h300, 4'd1, 3'd3, 2'b01);
        expect_acc(22'h300, 0); expect_acc(22'h308, 1);
        wait_accept("acc_stall_a");
        present(4'b0001, 2'd2, 22'h200, 4'd0, 3'd4, 2'b01);
        expect_acc(22'h200, 0); expect_acc(22'h208, 1);
        for (int i = 0; i < 3; i++) begin
            check("stall_o_addr", 32'(O_ADDR), 32'h300);
            check("stall_o_last", 32'(O_LAST), 32'd0);
            check("stall_o_valid", 32'(O_VALID), 32'd1);
            check("stall_ready", 32'(READY), 32'd0);
            tick();
        end
        O_READY = 1'b1;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (READY) begin
                check("idle_gap_o_valid", 32'(O_VALID), 32'd0);
                got = 1;
                break;
            end
            tick();
        end
        if (!got) fail_now("stall_release");
        wait_accept("acc_stall_b");
        check("b2b_o_valid", 32'(O_VALID), 32'd1);
        wait_drain("drain_stall");

        // Unaligned INCR start, BURST=11 as INCR
        present(4'b0010, 2'd2, 22'h103, 4'd2, 3'd2, 2'b11);
        expect_acc(22'h103, 0); expect_acc(22'h104, 0); expect_acc(22'h108, 1);
        wait_accept("acc_unaligned");
        wait_drain("drain_unaligned");

        // Single access
        present(4'b0100, 2'd0, 22'h55, 4'd0, 3'd2, 2'b01);
        expect_acc(22'h55, 1);
        wait_accept("acc_single");
        wait_drain("drain_single");

        // INCR crossing a 4KB page
        present(4'b1000, 2'd3, 22'hFF8, 4'd1, 3'd3, 2'b01);
        expect_acc(22'hFF8, 0); expect_acc(22'h1000, 1);
        wait_accept("acc_page");
        wait_drain("drain_page");
`ifdef AXI_ADDR_LATCH_4K_CHECK_EN
        check("o_err_page", 32'(O_ERR), 32'd1);
`endif

        // Top of address space rolls over
        present(4'b0001, 2'd1, 22'h3FFFF8, 4'd1, 3'd3, 2'b01);
        expect_acc(22'h3FFFF8, 0); expect_acc(22'h0, 1);
        wait_accept("acc_top");
        wait_drain("drain_top");
`ifdef AXI_ADDR_LATCH_4K_CHECK_EN
        check("o_err_top", 32'(O_ERR), 32'd1);
`endif

        // WRAP with 16-byte beats split into 8-byte accesses
        present(4'b0010, 2'd2, 22'h130, 4'd1, 3'd4, 2'b10);
        expect_acc(22'h130, 0); expect_acc(22'h138, 0);
        expect_acc(22'h120, 0); expect_acc(22'h128, 1);
        wait_accept("acc_wrap_wide");
        wait_drain("drain_wrap_wide");
`ifdef AXI_ADDR_LATCH_4K_CHECK_EN
        check("o_err_cleared", 32'(O_ERR), 32'd0);
`endif

        // FIXED with 16-byte beats: sub-accesses advance, each beat restarts at ADDR
        present(4'b0100, 2'd3, 22'h80, 4'd1, 3'd4, 2'b00);
        expect_acc(22'h80, 0); expect_acc(22'h88, 0);
        expect_acc(22'h80, 0); expect_acc(22'h88, 1);
        wait_accept("acc_fixed_wide");
        wait_drain("drain_fixed_wide");

        // Reset during second access of an 8-beat burst
        present(4'b1000, 2'd0, 22'h400, 4'd7, 3'd3, 2'b01);
        for (int i = 0; i < 8; i++) expect_acc(22'h400 + 22'(8 * i), (i == 7));
        wait_accept("acc_rst_burst");
        tick();
        check("rst_mid_beat2_addr", 32'(O_ADDR), 32'h408);
        RESET = 1'b1;
        exp_q.delete();
        tick();
        check("rst_mid_o_valid", 32'(O_VALID), 32'd0);
        check("rst_mid_o_last", 32'(O_LAST), 32'd0);
        check("rst_mid_o_addr", 32'(O_ADDR), 32'd0);
        check("rst_mid_ready", 32'(READY), 32'd0);
        RESET = 1'b0;
        #1;
        check("rst_mid_ready_release", 32'(READY), 32'd1);
        present(4'b0001, 2'd1, 22'h500, 4'd0, 3'd3, 2'b01);
        expect_acc(22'h500, 1);
        wait_accept("acc_after_rst");
        wait_drain("drain_after_rst");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
